exp_scheduler: RTL

EXP_SCHEDULER -- requirements
Module: exp_scheduler

---
 rtl/exp_scheduler_pkg.sv | 21 ++
 rtl/exp_scheduler_if.sv | 32 +++
 rtl/exp_rr_arbiter.sv | 37 +++
 rtl/exp_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/exp_scheduler_pkg.sv
// Shared types and constants for the exponent-accelerator scheduler.
// Optional watchdog feature is enabled by defining EXP_SCHEDULER_TIMEOUT_EN.
package exp_scheduler_pkg;

  localparam int DATA_W          = 32;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESPOND,
    ST_DRAIN
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp_scheduler_if.sv
// Requester and accelerator signal bundle for exp_scheduler.
// master: requesters plus accelerator (environment side); slave: the scheduler.
interface exp_scheduler_if
  import exp_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_p;
  logic                      rsp_err;
  logic                      acc_enable;
  logic [DATA_W-1:0]         acc_x;
  logic [DATA_W-1:0]         acc_a;
  logic [DATA_W-1:0]         acc_p;
  logic                      acc_ready;

  modport master (
    output req_valid, req_x, req_a, acc_p, acc_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_err, acc_enable, acc_x, acc_a
  );

  modport slave (
    input  req_valid, req_x, req_a, acc_p, acc_ready,
    output req_ready, rsp_valid, rsp_p, rsp_err, acc_enable, acc_x, acc_a
  );

endinterface

// File: rtl/exp_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rrPtr_i,
// wrapping from the highest index back to zero.
module exp_rr_arbiter
  import exp_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W  = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid_i,
  input  logic [IDX_W-1:0]   rrPtr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grantIdx_o,
  output logic               anyValid_o
);

  logic found;
  int   cand;

  // Scan from the pointer upward with wraparound; the first hit wins.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyValid_o = |reqValid_i;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rrPtr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && reqValid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grantIdx_o    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/exp_scheduler.sv
// Shares one exponent accelerator among NUM_REQ requesters, round-robin.
// Define EXP_SCHEDULER_TIMEOUT_EN to add a watchdog that aborts a stuck job
// after TIMEOUT_CYCLES and drains the accelerator before the next grant.
module exp_scheduler
  import exp_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  exp_scheduler_if.slave  bus,
  output logic            busy_o
);

  localparam int IDX_W = idxWidth(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    opX_q, opX_d;
  logic [DATA_W-1:0]    opA_q, opA_d;
  logic [DATA_W-1:0]    rspP_q, rspP_d;
  logic                 accReadyPrev_q;

  logic [NUM_REQ-1:0]   arbGrant;
  logic [IDX_W-1:0]     arbIdx;
  logic                 arbAny;

  logic                 grantFire;
  logic                 timeoutHit;
  logic                 errFlag;
  logic [NUM_REQ-1:0]   reqReady;
  logic [NUM_REQ-1:0]   rspValid;
  logic                 accEnable;

  exp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .reqValid_i (bus.req_valid),
    .rrPtr_i    (rrPtr_q),
    .grant_o    (arbGrant),
    .grantIdx_o (arbIdx),
    .anyValid_o (arbAny)
  );

`ifdef EXP_SCHEDULER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             rspErr_q, rspErr_d;

  // Watchdog counts only while a job is outstanding at the accelerator.
  always_comb begin
    tmoCnt_d = tmoCnt_q;
    rspErr_d = rspErr_q;
    if (grantFire) begin
      tmoCnt_d = '0;
      rspErr_d = 1'b0;
    end else if (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) begin
      tmoCnt_d = tmoCnt_q + 1'b1;
      if (timeoutHit) rspErr_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmoCnt_q <= '0;
      rspErr_q <= 1'b0;
    end else begin
      tmoCnt_q <= tmoCnt_d;
      rspErr_q <= rspErr_d;
    end
  end

  assign timeoutHit  = (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) &&
                       (tmoCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign errFlag     = rspErr_q;
  assign bus.rsp_err = rspErr_q && (state_q == ST_RESPOND);
`else
  logic unusedCfg;

  assign timeoutHit  = 1'b0;
  assign errFlag     = 1'b0;
  assign bus.rsp_err = 1'b0;
  assign unusedCfg   = grantFire & (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and handshake decode for the scheduling FSM.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    idx_d     = idx_q;
    opX_d     = opX_q;
    opA_d     = opA_q;
    rspP_d    = rspP_q;
    grantFire = 1'b0;
    reqReady  = '0;
    rspValid  = '0;
    accEnable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arbAny && bus.acc_ready && accReadyPrev_q) begin
          grantFire = 1'b1;
          reqReady  = arbGrant;
          idx_d     = arbIdx;
          opX_d     = bus.req_x[int'(arbIdx)*DATA_W +: DATA_W];
          opA_d     = bus.req_a[int'(arbIdx)*DATA_W +: DATA_W];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        accEnable = 1'b1;
        if (timeoutHit) begin
          rspP_d  = '0;
          state_d = ST_RESPOND;
        end else if (!bus.acc_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (timeoutHit) begin
          rspP_d  = '0;
          state_d = ST_RESPOND;
        end else if (bus.acc_ready) begin
          rspP_d  = bus.acc_p;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rspValid[idx_q] = 1'b1;
        rrPtr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = errFlag ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.acc_ready && accReadyPrev_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, latched operands and result; acc_ready history for qualification.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rrPtr_q        <= '0;
      idx_q          <= '0;
      opX_q          <= '0;
      opA_q          <= '0;
      rspP_q         <= '0;
      accReadyPrev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rrPtr_q        <= rrPtr_d;
      idx_q          <= idx_d;
      opX_q          <= opX_d;
      opA_q          <= opA_d;
      rspP_q         <= rspP_d;
      accReadyPrev_q <= bus.acc_ready;
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.rsp_valid  = rspValid;
  assign bus.rsp_p      = rspP_q;
  assign bus.acc_enable = accEnable;
  assign bus.acc_x      = opX_q;
  assign bus.acc_a      = opA_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
